// File: rtl/ex_mem_stage_unit.sv
// EX/MEM pipeline register, MEM-stage branch resolution, wait-stated data memory
// handshake with timeout, and the registered MEM/WB bundle.
module ex_mem_stage_unit #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   input  logic [3:0]        M_control_signals,
   input  logic [1:0]        WB_control_signals,
   input  logic [DATA_W-1:0] ex_alu_result,
   input  logic              ex_zero,
   input  logic [DATA_W-1:0] ex_store_data,
   input  logic [DATA_W-1:0] ex_branch_target,
   input  logic [4:0]        ex_rd,
   output logic              pc_src,
   output logic [DATA_W-1:0] pc_target,
   output logic              flush,
   output logic              stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_err,
   output logic              wb_valid,
   output logic              wb_reg_write,
   output logic              wb_mem_to_reg,
   output logic [4:0]        wb_rd,
   output logic [DATA_W-1:0] wb_alu_result,
   output logic [DATA_W-1:0] wb_mem_data
);

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_t;

   state_t            r_state;
   logic [7:0]        r_cnt;
   logic              r_err;

   logic              r_m_valid;
   logic              r_m_bne;
   logic              r_m_beq;
   logic              r_m_read;
   logic              r_m_write;
   logic              r_m_regwrite;
   logic              r_m_memtoreg;
   logic              r_m_zero;
   logic [4:0]        r_m_rd;
   logic [DATA_W-1:0] r_m_alu;
   logic [DATA_W-1:0] r_m_store;
   logic [DATA_W-1:0] r_m_target;

   logic              r_wb_valid;
   logic              r_wb_regwrite;
   logic              r_wb_memtoreg;
   logic [4:0]        r_wb_rd;
   logic [DATA_W-1:0] r_wb_alu;
   logic [DATA_W-1:0] r_wb_mdata;

   logic              w_access;
   logic              w_abort;
   logic              w_stall;
   logic              w_taken;
   logic              w_cap_valid;
   logic              w_read_ack;

   assign w_access    = r_m_valid & (r_m_read | r_m_write);
   assign w_abort     = w_access & (r_state == S_WAIT) & ~mem_ack & (r_cnt == 8'(TIMEOUT));
   assign w_stall     = w_access & ~mem_ack & ~w_abort;
   // Branches resolve only in the IDLE (first) MEM cycle, never again while stalled.
   assign w_taken     = r_m_valid & (r_state == S_IDLE) &
                        ((r_m_beq & r_m_zero) | (r_m_bne & ~r_m_zero));
   assign w_cap_valid = ex_valid & ~w_taken;
   assign w_read_ack  = w_access & mem_ack & r_m_read & ~r_m_write;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m_valid    <= 1'b0;
         r_m_bne      <= 1'b0;
         r_m_beq      <= 1'b0;
         r_m_read     <= 1'b0;
         r_m_write    <= 1'b0;
         r_m_regwrite <= 1'b0;
         r_m_memtoreg <= 1'b0;
         r_m_zero     <= 1'b0;
         r_m_rd       <= '0;
         r_m_alu      <= '0;
         r_m_store    <= '0;
         r_m_target   <= '0;
      end else if (!w_stall) begin
         r_m_valid    <= w_cap_valid;
         r_m_bne      <= w_cap_valid & M_control_signals[3];
         r_m_beq      <= w_cap_valid & M_control_signals[2];
         r_m_read     <= w_cap_valid & M_control_signals[1];
         r_m_write    <= w_cap_valid & M_control_signals[0];
         r_m_regwrite <= w_cap_valid & WB_control_signals[1];
         r_m_memtoreg <= w_cap_valid & WB_control_signals[0];
         r_m_zero     <= ex_zero;
         r_m_rd       <= ex_rd;
         r_m_alu      <= ex_alu_result;
         r_m_store    <= ex_store_data;
         r_m_target   <= ex_branch_target;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         if (w_abort) begin
            r_err <= 1'b1;
         end
         case (r_state)
            S_IDLE: begin
               if (w_access && !mem_ack) begin
                  r_state <= S_WAIT;
                  r_cnt   <= 8'd1;
               end
            end
            S_WAIT: begin
               if (mem_ack || w_abort) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wb_valid    <= 1'b0;
         r_wb_regwrite <= 1'b0;
         r_wb_memtoreg <= 1'b0;
         r_wb_rd       <= '0;
         r_wb_alu      <= '0;
         r_wb_mdata    <= '0;
      end else if (w_stall) begin
         r_wb_valid    <= 1'b0;
         r_wb_regwrite <= 1'b0;
         r_wb_memtoreg <= 1'b0;
      end else begin
         r_wb_valid    <= r_m_valid;
         r_wb_regwrite <= r_m_regwrite & ~w_abort;
         r_wb_memtoreg <= r_m_memtoreg;
         r_wb_rd       <= r_m_rd;
         r_wb_alu      <= r_m_alu;
         r_wb_mdata    <= w_read_ack ? mem_rdata : '0;
      end
   end

   assign pc_src        = w_taken;
   assign flush         = w_taken;
   assign pc_target     = r_m_target;
   assign stall         = w_stall;
   assign mem_req       = w_access;
   assign mem_we        = r_m_write;
   assign mem_addr      = r_m_alu;
   assign mem_wdata     = r_m_store;
   assign mem_err       = r_err;
   assign wb_valid      = r_wb_valid;
   assign wb_reg_write  = r_wb_regwrite;
   assign wb_mem_to_reg = r_wb_memtoreg;
   assign wb_rd         = r_wb_rd;
   assign wb_alu_result = r_wb_alu;
   assign wb_mem_data   = r_wb_mdata;

endmodule

// File: tb/tb_ex_mem_stage_unit.sv
// Transaction-level bench for ex_mem_stage_unit: each instruction's MEM-stage
// behaviour is predicted from its bundle and a chosen memory ack delay.
module tb_ex_mem_stage_unit;
   localparam int DW      = 32;
   localparam int TIMEOUT = 15;
   localparam int NEVER   = 1000;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ex_valid;
   logic [3:0]    M_control_signals;
   logic [1:0]    WB_control_signals;
   logic [DW-1:0] ex_alu_result;
   logic          ex_zero;
   logic [DW-1:0] ex_store_data;
   logic [DW-1:0] ex_branch_target;
   logic [4:0]    ex_rd;
   logic          pc_src;
   logic [DW-1:0] pc_target;
   logic          flush;
   logic          stall;
   logic          mem_req;
   logic          mem_we;
   logic [DW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ack;
   logic [DW-1:0] mem_rdata;
   logic          mem_err;
   logic          wb_valid;
   logic          wb_reg_write;
   logic          wb_mem_to_reg;
   logic [4:0]    wb_rd;
   logic [DW-1:0] wb_alu_result;
   logic [DW-1:0] wb_mem_data;

   ex_mem_stage_unit #(.DATA_W(DW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid),
      .M_control_signals(M_control_signals), .WB_control_signals(WB_control_signals),
      .ex_alu_result(ex_alu_result), .ex_zero(ex_zero), .ex_store_data(ex_store_data),
      .ex_branch_target(ex_branch_target), .ex_rd(ex_rd),
      .pc_src(pc_src), .pc_target(pc_target), .flush(flush), .stall(stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err),
      .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
      .wb_rd(wb_rd), .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          v;
      logic [3:0]    m;
      logic [1:0]    wb;
      logic [DW-1:0] alu;
      logic          z;
      logic [DW-1:0] st;
      logic [DW-1:0] tgt;
      logic [4:0]    rd;
      int            d;
      logic [DW-1:0] rdat;
   } txn_t;

   txn_t q[$];
   int   checks   = 0;
   int   failures = 0;
   logic model_err = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic txn_t mk(input logic v, input logic [3:0] m, input logic [1:0] wb,
                               input logic [DW-1:0] alu, input logic z, input logic [DW-1:0] st,
                               input logic [DW-1:0] tgt, input logic [4:0] rd, input int d,
                               input logic [DW-1:0] rdat);
      txn_t t;
      t.v = v; t.m = m; t.wb = wb; t.alu = alu; t.z = z; t.st = st;
      t.tgt = tgt; t.rd = rd; t.d = d; t.rdat = rdat;
      return t;
   endfunction

   function automatic txn_t rnd_txn();
      txn_t t;
      int   r;
      t = mk($urandom_range(0, 7) != 0, 4'b0000, 2'($urandom), $urandom, 1'($urandom),
             $urandom, $urandom, 5'($urandom), 0, $urandom);
      r = $urandom_range(0, 9);
      case (r)
         0, 1, 2, 3: t.m = 4'b0000;
         4, 5:       t.m = 4'b0010;
         6:          t.m = 4'b0001;
         7:          t.m = 4'b0100;
         8:          t.m = 4'b1000;
         default:    t.m = 4'($urandom);
      endcase
      r = $urandom_range(0, 9);
      if (r < 6)       t.d = $urandom_range(0, 4);
      else if (r < 8)  t.d = TIMEOUT - 1 + $urandom_range(0, 2);
      else if (r == 8) t.d = NEVER;
      else             t.d = $urandom_range(5, 13);
      return t;
   endfunction

   task automatic drive(input txn_t t);
      ex_valid           = t.v;
      M_control_signals  = t.m;
      WB_control_signals = t.wb;
      ex_alu_result      = t.alu;
      ex_zero            = t.z;
      ex_store_data      = t.st;
      ex_branch_target   = t.tgt;
      ex_rd              = t.rd;
   endtask

   // Walks q through MEM; the next instruction is offered exactly on the retire cycle.
   task automatic run_queue();
      txn_t          cur, nxt, bub;
      logic          eff_v, access, taken, abort, rd_ack;
      logic          p_v, p_rw, p_mtr, p_rdack;
      logic [4:0]    p_rd;
      logic [DW-1:0] p_alu, p_md;
      bit            has_prev;
      int            kend;
      bub = mk(1'b0, 4'b0, 2'b0, '0, 1'b0, '0, '0, 5'd0, 0, '0);
      has_prev = 0;
      p_v = 0; p_rw = 0; p_mtr = 0; p_rdack = 0; p_rd = '0; p_alu = '0; p_md = '0;
      @(negedge clk);
      mem_ack = 1'b0;
      drive(q[0]);
      eff_v = q[0].v;
      for (int i = 0; i < q.size(); i++) begin
         cur    = q[i];
         nxt    = (i + 1 < q.size()) ? q[i+1] : bub;
         access = eff_v & (cur.m[1] | cur.m[0]);
         taken  = eff_v & ((cur.m[2] & cur.z) | (cur.m[3] & ~cur.z));
         kend   = access ? ((cur.d < TIMEOUT) ? cur.d : TIMEOUT) : 0;
         abort  = access && (cur.d > TIMEOUT);
         rd_ack = access && cur.m[1] && !cur.m[0] && !abort;
         for (int k = 0; k <= kend; k++) begin
            @(negedge clk);
            if (k == 0) begin
               if (has_prev) begin
                  chk("wb_valid", wb_valid, p_v);
                  chk("wb_reg_write", wb_reg_write, p_rw);
                  chk("wb_mem_to_reg", wb_mem_to_reg, p_mtr);
                  if (p_v) begin
                     chk("wb_rd", wb_rd, p_rd);
                     chk("wb_alu_result", wb_alu_result, p_alu);
                  end
                  if (p_rdack) chk("wb_mem_data", wb_mem_data, p_md);
               end
            end else begin
               chk("wb_bubble_valid", wb_valid, 1'b0);
               chk("wb_bubble_rw", wb_reg_write, 1'b0);
            end
            mem_ack   = access ? (k == cur.d) : 1'($urandom);
            mem_rdata = (access && k == cur.d) ? cur.rdat : $urandom;
            if (k == kend) drive(nxt);
            else           drive(rnd_txn());
            #1;
            chk("mem_req", mem_req, access);
            chk("stall", stall, access && k < cur.d && k < TIMEOUT);
            chk("pc_src", pc_src, taken && k == 0);
            chk("flush", flush, taken && k == 0);
            chk("mem_err", mem_err, model_err);
            if (taken) chk("pc_target", pc_target, cur.tgt);
            if (access) begin
               chk("mem_we", mem_we, cur.m[0]);
               chk("mem_addr", mem_addr, cur.alu);
               chk("mem_wdata", mem_wdata, cur.st);
            end
         end
         model_err = model_err | abort;
         has_prev  = 1;
         p_v       = eff_v;
         p_rw      = eff_v & cur.wb[1] & ~abort;
         p_mtr     = eff_v & cur.wb[0];
         p_rd      = cur.rd;
         p_alu     = cur.alu;
         p_rdack   = rd_ack;
         p_md      = cur.rdat;
         eff_v     = nxt.v & ~(taken && kend == 0);
      end
      @(negedge clk);
      mem_ack = 1'b0;
      chk("wb_valid_last", wb_valid, p_v);
      chk("wb_reg_write_last", wb_reg_write, p_rw);
      q.delete();
   endtask

   initial begin
      txn_t bub;
      bub = mk(1'b0, 4'b0, 2'b0, '0, 1'b0, '0, '0, 5'd0, 0, '0);
      rst_n = 1'b0;
      mem_ack = 1'b0;
      mem_rdata = '0;
      drive(bub);
      repeat (2) @(negedge clk);
      #1;
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_stall", stall, 1'b0);
      chk("rst_pc_src", pc_src, 1'b0);
      chk("rst_flush", flush, 1'b0);
      chk("rst_wb_valid", wb_valid, 1'b0);
      chk("rst_wb_alu", wb_alu_result, '0);
      chk("rst_mem_err", mem_err, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      q.push_back(mk(1, 4'b0000, 2'b10, 32'h1234, 0, 32'h0, 32'h0, 5'd5, 0, 32'h0));
      q.push_back(mk(1, 4'b0100, 2'b00, 32'h0, 1, 32'h0, 32'h40, 5'd0, 0, 32'h0));
      q.push_back(bub);
      q.push_back(mk(1, 4'b0100, 2'b00, 32'h0, 0, 32'h0, 32'h40, 5'd0, 0, 32'h0));
      q.push_back(mk(1, 4'b1000, 2'b00, 32'h0, 0, 32'h0, 32'h80, 5'd0, 0, 32'h0));
      q.push_back(bub);
      q.push_back(mk(1, 4'b0010, 2'b11, 32'h100, 0, 32'h0, 32'h0, 5'd7, 3, 32'hDEADBEEF));
      q.push_back(mk(1, 4'b0001, 2'b00, 32'h200, 0, 32'hCAFE0001, 32'h0, 5'd0, 0, 32'h0));
      q.push_back(mk(1, 4'b0010, 2'b11, 32'h300, 0, 32'h0, 32'h0, 5'd9, NEVER, 32'h0));
      q.push_back(mk(1, 4'b1100, 2'b00, 32'h0, 0, 32'h0, 32'hC0, 5'd0, 0, 32'h0));
      q.push_back(mk(1, 4'b0110, 2'b11, 32'h400, 1, 32'h0, 32'h500, 5'd3, 2, 32'h12345678));
      q.push_back(mk(1, 4'b0011, 2'b10, 32'h600, 0, 32'h55AA, 32'h0, 5'd4, 1, 32'h0));
      for (int n = 0; n < 80; n++) q.push_back(rnd_txn());
      run_queue();

      // Reset while a read sits in WAIT.
      @(negedge clk);
      drive(mk(1, 4'b0010, 2'b11, 32'h700, 0, 32'h0, 32'h0, 5'd2, 0, 32'h0));
      mem_ack = 1'b0;
      @(negedge clk);
      drive(bub);
      @(negedge clk);
      #1;
      chk("wait_stall", stall, 1'b1);
      chk("wait_mem_req", mem_req, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_mem_req", mem_req, 1'b0);
      chk("async_rst_stall", stall, 1'b0);
      chk("async_rst_pc_src", pc_src, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_wb_valid", wb_valid, 1'b0);
      chk("post_rst_mem_err", mem_err, 1'b0);
      model_err = 1'b0;

      q.push_back(mk(1, 4'b0010, 2'b11, 32'h800, 0, 32'h0, 32'h0, 5'd1, 2, 32'hA5A5A5A5));
      for (int n = 0; n < 40; n++) q.push_back(rnd_txn());
      run_queue();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ex_mem_stage_unit.md
Name: ex_mem_stage_unit

Overview:
- Consumer end of the instruction decoder's control bundles.
- Holds the EX/MEM pipeline register and resolves BEQ/BNE in the MEM stage, driving PC select and flush back to fetch/decode.
- Runs a req/ack handshake FSM to a wait-stated data memory and stalls the pipeline while an access is outstanding.
- Produces the registered MEM/WB bundle.

Parameters:
- DATA_W, 32, width of address, ALU result, store data and load data
- TIMEOUT, 15, max wait cycles after first request cycle before an access is aborted (1..255)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX stage holds a real instruction
- M_control_signals  in  4  {BNE, BEQ, MemRead, MemWrite}, decoder packing
- WB_control_signals  in  2  {RegWrite, MemToReg}, decoder packing
- ex_alu_result  in  DATA_W  ALU result / memory address
- ex_zero  in  1  ALU zero flag
- ex_store_data  in  DATA_W  rt value for stores
- ex_branch_target  in  DATA_W  computed branch target
- ex_rd  in  5  destination register
- pc_src  out  1  take branch target this cycle
- pc_target  out  DATA_W  branch target
- flush  out  1  kill IF/ID and ID/EX contents
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- mem_req  out  1  data memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  DATA_W  access address
- mem_wdata  out  DATA_W  store data
- mem_ack  in  1  memory completed access (rdata valid when read)
- mem_rdata  in  DATA_W  load data
- mem_err  out  1  sticky: an access timed out
- wb_valid  out  1  MEM/WB holds a real instruction
- wb_reg_write  out  1  RegWrite to WB
- wb_mem_to_reg  out  1  MemToReg to WB
- wb_rd  out  5  destination register
- wb_alu_result  out  DATA_W  registered ALU result
- wb_mem_data  out  DATA_W  registered load data

Behaviour:
- Reset (async, rst_n=0): EX/MEM and MEM/WB registers cleared (valid=0, all controls 0, data 0); FSM=IDLE; wait counter=0; mem_err=0.
- Reset forces mem_req, stall, pc_src and flush low immediately.
- EX/MEM capture: on each edge with stall=0, load all ex_* inputs and bundles.
- EX/MEM bubble: if ex_valid=0 or flush=1 in that cycle, the captured valid and all control bits are 0.
- EX/MEM hold: with stall=1, the register holds its contents.
- Branch (combinational from EX/MEM): taken = m_valid & ((BEQ & zero) | (BNE & ~zero)).
- Branch with BEQ and BNE both set: unconditional taken.
- Branch outputs: pc_src = flush = taken; pc_target = registered branch target.
- Branch with a memory bit also set: branch resolves in its first MEM cycle only, never repeated while stalled.
- Access: m_valid & (MemRead | MemWrite). mem_we = MemWrite; write wins if both bits are set.
- mem_addr = registered ALU result; mem_wdata = registered store data.
- FSM IDLE: with an access in EX/MEM, mem_req=1.
  - mem_ack=1 in the same cycle: zero-wait; retire; stall=0.
  - Otherwise: stall=1, go to WAIT, counter=1.
- FSM WAIT: mem_req=1, stall=1, counter increments each cycle.
  - mem_ack=1: retire; stall=0 that cycle; go to IDLE.
  - mem_ack=0 with counter==TIMEOUT: abort; mem_err set (sticky until reset); retire with RegWrite forced 0; go to IDLE.
- stall is combinational: access pending & ~mem_ack & ~abort.
- mem_req never drops before ack/abort; mem_addr, mem_we and mem_wdata stay stable while mem_req=1.
- Retire: on the edge where the MEM instruction completes (no access, or ack, or abort), MEM/WB loads valid, RegWrite, MemToReg, rd, ALU result, and mem_rdata when a read was acked.
- MEM/WB during a stall: loads a bubble (wb_valid=0, controls 0).
- Latency: non-memory instruction reaches MEM/WB one cycle after entering MEM. Memory instruction reaches MEM/WB 1 + wait cycles after entering MEM.
- mem_ack with no request outstanding: ignored.
- flush never affects EX/MEM's current occupant or MEM/WB.

Test Plan:
- ADD-type: bundles WB=2'b10, M=4'b0000, alu=0x1234, rd=5 -> next cycle wb_valid=1, wb_reg_write=1, wb_alu_result=0x1234, no mem_req, stall=0.
- BEQ with zero=1, target=0x40 -> pc_src=1, flush=1 for exactly one cycle, pc_target=0x40. Same instruction with zero=0 -> pc_src=0. BNE with zero=0 -> taken.
- Load M=4'b0010, WB=2'b11, addr=0x100, mem_ack after 3 wait cycles, rdata=0xDEADBEEF -> mem_req high 4 cycles, stall high 3 cycles, addr stable, then wb_mem_data=0xDEADBEEF, wb_mem_to_reg=1.
- Store M=4'b0001 with same-cycle ack -> mem_we=1, mem_wdata=store data, stall never asserted, wb_reg_write=0.
- Read with ack never given, TIMEOUT=15 -> stall for 15 cycles, then mem_req=0, mem_err=1, wb_valid=1 with wb_reg_write=0; mem_err stays 1 until rst_n low.
- rst_n pulsed low while in WAIT -> mem_req/stall drop immediately; after release, wb_valid=0, mem_err=0, FSM=IDLE.
